// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller: register-number width,
// controller state encoding and operand-forwarding select codes.
package pipe_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding select for one ID-stage source register.
// Ports:
//   active     in  1      controller is in a state where forwarding applies
//   rs         in  REG_W  source register number
//   mem_rd     in  REG_W  MEM-stage destination, mem_wr_en in 1
//   wb_rd      in  REG_W  WB-stage destination,  wb_wr_en  in 1
//   fwd_sel    out 2      FWD_RF / FWD_MEM / FWD_WB
module pipe_fwd_unit
  import pipe_pkg::*;
(
  input  logic             active,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wr_en,
  output logic [1:0]       fwd_sel
);

  // The MEM-stage result is younger than the WB one, so it wins when both
  // match. R0 is not special-cased.
  always_comb begin
    fwd_sel = FWD_RF;
    if (active) begin
      if (mem_wr_en && (mem_rd == rs))
        fwd_sel = FWD_MEM;
      else if (wb_wr_en && (wb_rd == rs))
        fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central controller for the 5-stage 16-bit pipeline: stage enables and
// flushes, load-use / branch hazard handling, data-memory stall with timeout,
// operand forwarding selects, and post-reset clearing of the pipeline regs.
//
// State table:
//   INIT     | forced flush of every stage for INIT_CYC cycles after reset
//   RUN      | normal issue; hazards resolved by priority
//   MEM_WAIT | data memory busy, upstream stages frozen until ack/timeout
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_rs1/2, id_rs1/2_used   ID-stage sources and whether they are read
//   ex_rd/ex_wr_en/ex_is_load EX-stage destination info
//   mem_rd/mem_wr_en          MEM-stage destination info
//   wb_rd/wb_wr_en            WB-stage destination info
//   ex_br_taken               taken branch resolved in EX
//   mem_req/mem_ack           data memory handshake
//   *_en, *_flush             stage register load enables / bubble inserts
//   fwd_a_sel/fwd_b_sel       operand forwarding selects
//   mem_err                   sticky memory timeout flag
//   stall_cycles              saturating count of stalled (pc_en=0) cycles
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int INIT_CYC    = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_wr_en,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_wr_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_wr_en,
  input  logic             ex_br_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int INIT_W = (INIT_CYC > 2) ? $clog2(INIT_CYC) : 1;

  logic [1:0]        state;
  logic [INIT_W-1:0] init_cnt;
  logic [7:0]        wait_cnt;
  logic              load_use;
  logic              wait_timeout;
  logic              fwd_active;

  assign load_use = ex_is_load && ex_wr_en &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  assign wait_timeout = (wait_cnt == 8'(MEM_TIMEOUT));
  assign fwd_active   = !rst && ((state == ST_RUN) || (state == ST_MEM_WAIT));

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst || !((state == ST_RUN) || (state == ST_MEM_WAIT))) begin
      // Pipeline regs have no reset: keep loading bubbles everywhere.
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if ((state == ST_RUN) ? (mem_req && !mem_ack)
                                   : (!mem_ack && !wait_timeout)) begin
      // Freeze everything upstream of MEM; WB drains and gets a bubble.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state == ST_RUN) begin
      // Hazards are only evaluated in RUN; in MEM_WAIT the release cycle is
      // a plain advance and frozen stages re-evaluate on the next cycle.
      if (ex_br_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      init_cnt     <= '0;
      wait_cnt     <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + INIT_W'(1);
          if (init_cnt == INIT_W'(INIT_CYC - 1))
            state <= ST_RUN;
        end
        ST_RUN: begin
          if (mem_req && !mem_ack) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ack) begin
            state <= ST_RUN;
          end else if (wait_timeout) begin
            mem_err <= 1'b1;
            state   <= ST_RUN;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ST_INIT;
      endcase

      if (((state == ST_RUN) || (state == ST_MEM_WAIT)) && !pc_en &&
          (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  pipe_fwd_unit u_fwd_a (
    .active    (fwd_active),
    .rs        (id_rs1),
    .mem_rd    (mem_rd),
    .mem_wr_en (mem_wr_en),
    .wb_rd     (wb_rd),
    .wb_wr_en  (wb_wr_en),
    .fwd_sel   (fwd_a_sel)
  );

  pipe_fwd_unit u_fwd_b (
    .active    (fwd_active),
    .rs        (id_rs2),
    .mem_rd    (mem_rd),
    .mem_wr_en (mem_wr_en),
    .wb_rd     (wb_rd),
    .wb_wr_en  (wb_wr_en),
    .fwd_sel   (fwd_b_sel)
  );

endmodule
